// File: rtl/uart_reg_master.sv
// UART initiator for the register-access protocol: sends write/read command frames
// (8N1, LSB first) and captures the 2-byte read response with timeout and framing checks.
module uart_reg_master #(
    parameter int CLKS_PER_BIT = 434,
    parameter int RSP_TIMEOUT  = 500000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_rdata,
    output logic        o_uart_tx,
    input  logic        i_uart_rx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(RSP_TIMEOUT - 1);
    localparam logic [7:0]    CMD_WR    = 8'h57;
    localparam logic [7:0]    CMD_RD    = 8'h52;

    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        RX_WAIT,
        RX_START,
        RX_DATA,
        RX_STOP,
        FIN
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [CW-1:0]   r_clkCnt;
    logic [2:0]      r_bitIdx;
    logic [2:0]      r_byteIdx;
    logic [7:0]      r_txShift;
    logic            r_tx;
    logic            r_wr;
    logic [15:0]     r_addr;
    logic [15:0]     r_wdata;
    logic [1:0]      r_rxSync;
    logic [7:0]      r_rxShift;
    logic [7:0]      r_rxByte0;
    logic [TW-1:0]   r_toCnt;
    logic            r_err;
    logic [15:0]     r_rdata;

    logic            w_rx;
    logic            w_bitEnd;
    logic            w_halfPoint;
    logic            w_lastTxByte;
    logic            w_timeout;
    logic            w_stateChange;
    logic [7:0]      w_nextByte;

    assign w_rx          = r_rxSync[1];
    assign w_bitEnd      = (r_clkCnt == BIT_LAST);
    assign w_halfPoint   = (r_clkCnt == HALF_LAST);
    assign w_lastTxByte  = r_wr ? (r_byteIdx == 3'd4) : (r_byteIdx == 3'd2);
    assign w_timeout     = (r_toCnt == TO_LAST);
    assign w_stateChange = (w_stateNext != r_state);

    // Byte that follows the one currently on the line; byte 0 is the command.
    always_comb begin
        w_nextByte = 8'h00;
        case (r_byteIdx)
            3'd0:    w_nextByte = r_addr[15:8];
            3'd1:    w_nextByte = r_addr[7:0];
            3'd2:    w_nextByte = r_wdata[15:8];
            3'd3:    w_nextByte = r_wdata[7:0];
            default: w_nextByte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rxSync <= 2'b11;
        end else begin
            r_rxSync <= {r_rxSync[0], i_uart_rx};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A low line in RX_WAIT wins over a simultaneous timeout; a rejected glitch
    // falls back into RX_WAIT with the timeout still running.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:     if (i_req) w_stateNext = TX_START;
            TX_START: if (w_bitEnd) w_stateNext = TX_DATA;
            TX_DATA:  if (w_bitEnd && (r_bitIdx == 3'd7)) w_stateNext = TX_STOP;
            TX_STOP: begin
                if (w_bitEnd) begin
                    if (!w_lastTxByte) w_stateNext = TX_START;
                    else if (r_wr)     w_stateNext = FIN;
                    else               w_stateNext = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (!w_rx)          w_stateNext = RX_START;
                else if (w_timeout) w_stateNext = FIN;
            end
            RX_START: if (w_halfPoint) w_stateNext = w_rx ? RX_WAIT : RX_DATA;
            RX_DATA:  if (w_bitEnd && (r_bitIdx == 3'd7)) w_stateNext = RX_STOP;
            RX_STOP: begin
                if (w_bitEnd) w_stateNext = (!w_rx || r_byteIdx[0]) ? FIN : RX_WAIT;
            end
            FIN:      w_stateNext = IDLE;
            default:  w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clkCnt  <= '0;
            r_bitIdx  <= '0;
            r_byteIdx <= '0;
            r_txShift <= '0;
            r_tx      <= 1'b1;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rxShift <= '0;
            r_rxByte0 <= '0;
            r_toCnt   <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_stateChange || w_bitEnd) begin
                r_clkCnt <= '0;
            end else begin
                r_clkCnt <= r_clkCnt + 1'b1;
            end

            if (w_stateChange) begin
                r_bitIdx <= '0;
            end else if (w_bitEnd && ((r_state == TX_DATA) || (r_state == RX_DATA))) begin
                r_bitIdx <= r_bitIdx + 1'b1;
            end

            // The tx line is registered and changes together with the state.
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_wr      <= i_wr;
                        r_addr    <= i_addr;
                        r_wdata   <= i_wdata;
                        r_err     <= 1'b0;
                        r_byteIdx <= '0;
                        r_txShift <= i_wr ? CMD_WR : CMD_RD;
                        r_tx      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_bitEnd) r_tx <= r_txShift[0];
                end
                TX_DATA: begin
                    if (w_bitEnd) begin
                        r_txShift <= {1'b0, r_txShift[7:1]};
                        r_tx      <= (r_bitIdx == 3'd7) ? 1'b1 : r_txShift[1];
                    end
                end
                TX_STOP: begin
                    if (w_bitEnd) begin
                        if (!w_lastTxByte) begin
                            r_byteIdx <= r_byteIdx + 1'b1;
                            r_txShift <= w_nextByte;
                            r_tx      <= 1'b0;
                        end else begin
                            r_byteIdx <= '0;
                        end
                    end
                end
                RX_WAIT: begin
                    if (w_rx && w_timeout) r_err <= 1'b1;
                end
                RX_DATA: begin
                    if (w_bitEnd) r_rxShift <= {w_rx, r_rxShift[7:1]};
                end
                RX_STOP: begin
                    if (w_bitEnd) begin
                        if (!w_rx) begin
                            r_err <= 1'b1;
                        end else if (!r_byteIdx[0]) begin
                            r_rxByte0 <= r_rxShift;
                            r_byteIdx <= 3'd1;
                        end else begin
                            r_rdata <= {r_rxByte0, r_rxShift};
                        end
                    end
                end
                default: ;
            endcase

            // Saturating response timer, restarted per byte and on each confirmed start.
            if (((r_state == TX_STOP) || (r_state == RX_STOP)) && (w_stateNext == RX_WAIT)) begin
                r_toCnt <= '0;
            end else if ((r_state == RX_START) && w_halfPoint && !w_rx) begin
                r_toCnt <= '0;
            end else if (((r_state == RX_WAIT) || (r_state == RX_START)) && !w_timeout) begin
                r_toCnt <= r_toCnt + 1'b1;
            end
        end
    end

    assign o_busy    = (r_state != IDLE) && (r_state != FIN);
    assign o_done    = (r_state == FIN);
    assign o_err     = r_err;
    assign o_rdata   = r_rdata;
    assign o_uart_tx = r_tx;

endmodule

// File: tb/tb_uart_reg_master.sv
// Self-checking bench for uart_reg_master: tx bytes are scoreboarded against a queue
// filled at request time; a UART responder model drives the rx line.
`timescale 1ns/1ps
module tb_uart_reg_master;

    localparam int CPB      = 8;
    localparam int TMO      = 1000;
    localparam int BYTE_CYC = 10 * CPB;
    localparam int RD_FRAME = 1 + 30 * CPB;
    localparam int WR_DONE  = 1 + 50 * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic        tx;
    logic        rx;

    typedef struct {
        logic [7:0] data;
        int         startCyc;
    } txExp_t;

    txExp_t      expTx[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          acceptCyc = 0;
    int          doneCount = 0;
    bit          monEnable = 1'b1;
    bit          gotDone;
    int          doneAt;
    logic        errAt;
    logic        busyAt;
    logic [15:0] rdAt;

    int          monStart;
    logic [7:0]  monByte;
    logic        monStartOk;
    logic        monStopOk;
    txExp_t      monExp;

    uart_reg_master #(
        .CLKS_PER_BIT (CPB),
        .RSP_TIMEOUT  (TMO)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_wr      (wr),
        .i_addr    (addr),
        .i_wdata   (wdata),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err),
        .o_rdata   (rdata),
        .o_uart_tx (tx),
        .i_uart_rx (rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) doneCount <= doneCount + 1;
    end

    // Decodes each tx byte at bit centres and compares it with the scoreboard head.
    always begin
        @(negedge clk);
        if (monEnable && (tx === 1'b0)) begin
            monStart = cyc;
            repeat (CPB / 2) @(negedge clk);
            monStartOk = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                monByte[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            monStopOk = (tx === 1'b1);
            checks++;
            if (expTx.size() == 0) begin
                errors++;
                $display("[TB] FAIL tx_unexpected: got byte 0x%02h at cycle %0d, expected no byte", monByte, monStart);
            end else begin
                monExp = expTx.pop_front();
                if ((monByte !== monExp.data) || (monStart != monExp.startCyc) || !monStartOk || !monStopOk) begin
                    errors++;
                    $display("[TB] FAIL tx_byte: got 0x%02h start@%0d startbit_ok=%b stopbit_ok=%b, expected 0x%02h start@%0d",
                             monByte, monStart, monStartOk, monStopOk, monExp.data, monExp.startCyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReq(input logic w, input logic [15:0] a, input logic [15:0] d, input bit track);
        logic [7:0] bytes [5];
        int n;
        @(negedge clk);
        req = 1'b1;
        wr = w;
        addr = a;
        wdata = d;
        acceptCyc = cyc;
        bytes[0] = w ? 8'h57 : 8'h52;
        bytes[1] = a[15:8];
        bytes[2] = a[7:0];
        bytes[3] = d[15:8];
        bytes[4] = d[7:0];
        n = w ? 5 : 3;
        if (track) begin
            for (int k = 0; k < n; k++) begin
                expTx.push_back('{data: bytes[k], startCyc: acceptCyc + 1 + k * BYTE_CYC});
            end
        end
        @(negedge clk);
        req = 1'b0;
        wr = 1'b0;
        addr = '0;
        wdata = '0;
    endtask

    task automatic waitDone(input int limit);
        int n;
        n = 0;
        gotDone = 1'b0;
        while ((done !== 1'b1) && (n < limit)) begin
            @(negedge clk);
            n++;
        end
        if (done === 1'b1) begin
            gotDone = 1'b1;
            doneAt = cyc;
            errAt = err;
            busyAt = busy;
            rdAt = rdata;
        end
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopBit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata: got 0x%04h expected 0x0000", rdata); end
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    endtask

    task automatic test_write;
        doReq(1'b1, 16'h0004, 16'h1234, 1'b1);
        checks++; if (busy !== 1'b1 || tx !== 1'b0) begin errors++; $display("[TB] FAIL write_accept: got busy=%b tx=%b expected busy=1 tx=0", busy, tx); end
        waitDone(1000);
        checks++; if (!gotDone) begin errors++; $display("[TB] FAIL write_done_seen: got no o_done, expected one"); end
        checks++; if (gotDone && doneAt != acceptCyc + WR_DONE) begin errors++; $display("[TB] FAIL write_latency: got cycle %0d expected %0d", doneAt, acceptCyc + WR_DONE); end
        checks++; if (gotDone && (errAt !== 1'b0 || busyAt !== 1'b0)) begin errors++; $display("[TB] FAIL write_done_flags: got err=%b busy=%b expected err=0 busy=0", errAt, busyAt); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL write_after_done: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (expTx.size() != 0) begin errors++; $display("[TB] FAIL write_bytes_left: got %0d pending expected 0", expTx.size()); end
    endtask

    task automatic test_read;
        doReq(1'b0, 16'h0000, 16'h0000, 1'b1);
        fork
            begin
                waitUntil(acceptCyc + RD_FRAME + 20 * CPB);
                sendByte(8'hAB, 1'b1);
                sendByte(8'hCD, 1'b1);
            end
            waitDone(2000);
        join
        checks++; if (!gotDone) begin errors++; $display("[TB] FAIL read_done_seen: got no o_done, expected one"); end
        checks++; if (gotDone && errAt !== 1'b0) begin errors++; $display("[TB] FAIL read_err: got %b expected 0", errAt); end
        checks++; if (gotDone && rdAt !== 16'hABCD) begin errors++; $display("[TB] FAIL read_rdata: got 0x%04h expected 0xabcd", rdAt); end
        checks++; if (expTx.size() != 0) begin errors++; $display("[TB] FAIL read_bytes_left: got %0d pending expected 0", expTx.size()); end
    endtask

    task automatic test_timeout;
        int startDone;
        doReq(1'b0, 16'h0042, 16'h0000, 1'b1);
        waitDone(3000);
        checks++; if (!gotDone) begin errors++; $display("[TB] FAIL timeout_done_seen: got no o_done, expected one"); end
        checks++; if (gotDone && doneAt != acceptCyc + RD_FRAME + TMO) begin errors++; $display("[TB] FAIL timeout_latency: got cycle %0d expected %0d", doneAt, acceptCyc + RD_FRAME + TMO); end
        checks++; if (gotDone && errAt !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", errAt); end
        checks++; if (gotDone && rdAt !== 16'hABCD) begin errors++; $display("[TB] FAIL timeout_rdata: got 0x%04h expected 0xabcd", rdAt); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_hold: got %b expected 1", err); end
        startDone = doneCount;
        sendByte(8'h99, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (doneCount != startDone || rdata !== 16'hABCD || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL late_byte_ignored: got dones=%0d rdata=0x%04h busy=%b expected 0 0xabcd 0", doneCount - startDone, rdata, busy);
        end
    endtask

    task automatic test_glitch;
        doReq(1'b0, 16'h0010, 16'h0000, 1'b1);
        fork
            begin
                waitUntil(acceptCyc + RD_FRAME + 40);
                rx = 1'b0;
                repeat (2) @(negedge clk);
                rx = 1'b1;
                waitUntil(acceptCyc + RD_FRAME + 200);
                sendByte(8'h13, 1'b1);
                sendByte(8'h57, 1'b1);
            end
            waitDone(2000);
        join
        checks++; if (!gotDone) begin errors++; $display("[TB] FAIL glitch_done_seen: got no o_done, expected one"); end
        checks++; if (gotDone && (errAt !== 1'b0 || rdAt !== 16'h1357)) begin errors++; $display("[TB] FAIL glitch_read: got err=%b rdata=0x%04h expected err=0 rdata=0x1357", errAt, rdAt); end
    endtask

    task automatic test_framing;
        doReq(1'b0, 16'h0020, 16'h0000, 1'b1);
        fork
            begin
                waitUntil(acceptCyc + RD_FRAME + 80);
                sendByte(8'h55, 1'b1);
                sendByte(8'h66, 1'b0);
            end
            waitDone(2000);
        join
        checks++; if (!gotDone) begin errors++; $display("[TB] FAIL framing_done_seen: got no o_done, expected one"); end
        checks++; if (gotDone && (errAt !== 1'b1 || rdAt !== 16'h1357)) begin errors++; $display("[TB] FAIL framing_err: got err=%b rdata=0x%04h expected err=1 rdata=0x1357", errAt, rdAt); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int startDone;
        startDone = doneCount;
        doReq(1'b1, 16'h0100, 16'hBEEF, 1'b1);
        waitUntil(acceptCyc + 100);
        req = 1'b1;
        wr = 1'b0;
        addr = 16'h7777;
        @(negedge clk);
        req = 1'b0;
        addr = '0;
        waitDone(1000);
        checks++; if (!gotDone || doneAt != acceptCyc + WR_DONE || errAt !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_ignore_done: got seen=%b cycle=%0d err=%b expected 1 %0d 0", gotDone, doneAt, errAt, acceptCyc + WR_DONE);
        end
        doReq(1'b1, 16'h0200, 16'h00FF, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL back_to_back_accept: got busy=%b expected 1", busy); end
        waitDone(1000);
        checks++; if (!gotDone || doneAt != acceptCyc + WR_DONE) begin
            errors++; $display("[TB] FAIL back_to_back_done: got seen=%b cycle=%0d expected 1 %0d", gotDone, doneAt, acceptCyc + WR_DONE);
        end
        repeat (50) @(negedge clk);
        checks++; if (doneCount - startDone != 2) begin errors++; $display("[TB] FAIL done_count: got %0d pulses expected 2", doneCount - startDone); end
        checks++; if (expTx.size() != 0) begin errors++; $display("[TB] FAIL b2b_bytes_left: got %0d pending expected 0", expTx.size()); end
    endtask

    task automatic test_reset_mid_write;
        int startDone;
        checks++; if (rdata !== 16'h1357) begin errors++; $display("[TB] FAIL pre_reset_rdata: got 0x%04h expected 0x1357", rdata); end
        monEnable = 1'b0;
        startDone = doneCount;
        doReq(1'b1, 16'h0004, 16'h1234, 1'b0);
        waitUntil(acceptCyc + 1 + 2 * BYTE_CYC + 2);
        checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL byte2_start: got tx=%b busy=%b expected tx=0 busy=1", tx, busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_lines: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
        checks++; if (rdata !== 16'h0000 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_regs: got rdata=0x%04h done=%b err=%b expected 0x0000 0 0", rdata, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        checks++; if (doneCount != startDone || tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_quiet: got dones=%0d tx=%b busy=%b expected 0 1 0", doneCount - startDone, tx, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0;
        wr = 1'b0;
        addr = '0;
        wdata = '0;
        rx = 1'b1;
        $display("[TB] starting uart_reg_master bench");
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
